alu_seq_unit: RTL and testbench

Parametrised execute-stage ALU that consumes the 4-bit ALU operation code from the opcode decoder and produces a registered result through a valid/ready handshake. It extends the original nine-operation set (add … slt) with unsigned compare, arithmetic shift right, and iterative multiply/divide. Single-cycle ops complete in one cycle; mul/div ops stall the handshake for WIDTH cycles. It sits between the ID/EX pipeline register and the EX/MEM register; `flush` kills in-flight work on branch mispredict.

---
 rtl/alu_seq_unit.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_unit
// Brief    : Execute-stage ALU with valid/ready handshake. Single-cycle logic,
//            compare and shift ops; iterative shift-add multiply and restoring
//            divide that occupy the unit for WIDTH cycles.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] C_CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOR   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_SRA   = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_MULHU = 4'hC;
    localparam logic [3:0] OP_DIVU  = 4'hD;
    localparam logic [3:0] OP_REMU  = 4'hE;
    localparam logic [3:0] OP_ILL   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor
    logic               is_div_q, is_div_d;
    logic               sel_hi_q, sel_hi_d; // take upper half of acc (mulhu / remu)
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               op_muldiv;
    logic               op_illegal;
    logic               accept;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_tmp;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   step_res;

    assign shamt      = b[SHW-1:0];
    assign op_muldiv  = MULDIV_EN && (alu_op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU});
    assign op_illegal = (alu_op == OP_ILL) ||
                        (!MULDIV_EN && (alu_op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU}));

    // Single-cycle datapath, evaluated on the live operands at accept time
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide on the accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        div_tmp   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_tmp >= {1'b0, opnd_q});
        div_rem   = div_ge ? WIDTH'(div_tmp - {1'b0, opnd_q}) : div_tmp[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
        step_next = is_div_q ? div_next : mul_next;
        step_res  = sel_hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
    end

    // Handshake FSM: next state, accept and result capture; flush overrides all
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        sel_hi_d  = sel_hi_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: accept = in_valid;
            ST_BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    result_d  = step_res;
                    zero_d    = (step_res == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    accept  = in_valid;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (op_muldiv) begin
                state_d  = ST_BUSY;
                cnt_d    = C_CNT_FULL;
                is_div_d = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
                sel_hi_d = (alu_op == OP_MULHU) || (alu_op == OP_REMU);
                // divide starts from {0, dividend}; multiply from {0, multiplier}
                acc_d    = is_div_d ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
                opnd_d   = is_div_d ? b : a;
            end else begin
                state_d   = ST_DONE;
                result_d  = op_illegal ? '0 : alu_res;
                zero_d    = op_illegal ? 1'b1 : (alu_res == '0);
                illegal_d = op_illegal;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            opnd_d  = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            sel_hi_q  <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            sel_hi_q  <= sel_hi_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_unit
// Brief    : Directed self-checking bench for alu_seq_unit (WIDTH=32), with a
//            second instance built with multiply/divide disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;

    logic        in_ready,  out_valid,  zero,  illegal;
    logic [31:0] result;
    logic        in_ready2, out_valid2, zero2, illegal2;
    logic [31:0] result2;

    int total = 0;
    int bad   = 0;

    alu_seq_unit #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    alu_seq_unit #(.WIDTH(32), .MULDIV_EN(1'b0)) dut_nomd (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .zero(zero2), .illegal(illegal2)
    );

    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit past it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add_wrap();
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = 4'h0; a = 32'hFFFF_FFFF; b = 32'h1;
        cyc();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_latency out_valid got=%b exp=1", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL add_wrap result got=%h exp=0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL add_wrap zero got=%b exp=1", zero); end
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_single_ops();
        logic [3:0]  ops [10];
        logic [31:0] va  [10];
        logic [31:0] vb  [10];
        logic [31:0] ve  [10];
        ops = '{4'h8, 4'h9, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        va  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5, 32'hF0F0,
                32'hF0F0, 32'hF0F0, 32'h0, 32'h1, 32'h8000_0000};
        vb  = '{32'h1, 32'h1, 32'h21, 32'h7, 32'hFF00,
                32'hFF00, 32'hFF00, 32'h0, 32'h24, 32'h1F};
        ve  = '{32'h1, 32'h0, 32'hC000_0000, 32'hFFFF_FFFE, 32'hF000,
                32'hFFF0, 32'h0FF0, 32'hFFFF_FFFF, 32'h10, 32'h1};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; a = va[i]; b = vb[i];
            cyc();
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || result !== ve[i]) begin
                bad++;
                $display("FAIL single_op[%0d] op=%h valid=%b result got=%h exp=%h", i, ops[i], out_valid, result, ve[i]);
            end
            total++;
            if (zero !== (ve[i] == 32'h0)) begin
                bad++;
                $display("FAIL single_zero[%0d] got=%b exp=%b", i, zero, (ve[i] == 32'h0));
            end
            cyc();
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops [8];
        logic [31:0] va  [8];
        logic [31:0] vb  [8];
        logic [31:0] ve  [8];
        int          ncyc;
        int          ready_bad;
        ops = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hD, 4'hE, 4'hB, 4'hC};
        va  = '{32'h10000, 32'h10000, 32'h7, 32'h7, 32'd100, 32'd100, 32'h3, 32'hFFFF_FFFF};
        vb  = '{32'h10000, 32'h10000, 32'h0, 32'h0, 32'd7,   32'd7,   32'h5, 32'hFFFF_FFFF};
        ve  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7, 32'd14, 32'd2, 32'd15, 32'hFFFF_FFFE};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; a = va[i]; b = vb[i];
            cyc();
            in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; alu_op = 4'h0;
            ncyc = 1;
            ready_bad = 0;
            while (out_valid !== 1'b1 && ncyc < 100) begin
                if (in_ready !== 1'b0) ready_bad++;
                cyc();
                ncyc++;
            end
            total++;
            if (ncyc !== 33) begin bad++; $display("FAIL muldiv_latency[%0d] got=%0d exp=33", i, ncyc); end
            total++;
            if (ready_bad !== 0) begin bad++; $display("FAIL muldiv_busy_in_ready[%0d] high_cycles got=%0d exp=0", i, ready_bad); end
            total++;
            if (result !== ve[i] || zero !== (ve[i] == 32'h0) || illegal !== 1'b0) begin
                bad++;
                $display("FAIL muldiv_result[%0d] op=%h got=%h z=%b il=%b exp=%h", i, ops[i], result, zero, illegal, ve[i]);
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 4'h0; a = 32'd3; b = 32'd4;
        cyc();
        // a second op stays offered while the consumer stalls
        a = 32'd1; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure[%0d] valid=%b result=%h in_ready=%b exp=1/7/0", i, out_valid, result, in_ready);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; alu_op = 4'h0; a = 32'd10; b = k;
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", k, in_ready); end
            cyc();
            total++;
            if (out_valid !== 1'b1 || result !== 32'd10 + k) begin
                bad++;
                $display("FAIL stream_result[%0d] valid=%b got=%h exp=%h", k, out_valid, result, 32'd10 + k);
            end
        end
        in_valid = 1'b0;
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = 4'hB; a = 32'd3; b = 32'd5;
        cyc();
        in_valid = 1'b0;
        repeat (8) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_idle valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            cyc();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_result valid_cycles got=%0d exp=0", seen); end
        // op offered together with flush is dropped
        flush = 1'b1; in_valid = 1'b1; alu_op = 4'h0; a = 32'd2; b = 32'd2;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_offer valid got=%b exp=0", out_valid); end
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || result !== 32'd4) begin
            bad++;
            $display("FAIL flush_recover valid=%b result got=%h exp=4", out_valid, result);
        end
        cyc();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = 4'hF; a = 32'd5; b = 32'd6;
        cyc();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL illegal_op valid=%b il=%b result=%h z=%b exp=1/1/0/1", out_valid, illegal, result, zero);
        end
        cyc();
        in_valid = 1'b1; alu_op = 4'h0; a = 32'd2; b = 32'd3;
        cyc();
        in_valid = 1'b0;
        total++;
        if (illegal !== 1'b0 || result !== 32'd5 || zero !== 1'b0) begin
            bad++;
            $display("FAIL legal_after_illegal il=%b result=%h z=%b exp=0/5/0", illegal, result, zero);
        end
        cyc();
    endtask

    task automatic test_muldiv_disabled();
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = 4'hB; a = 32'd3; b = 32'd5;
        cyc();
        in_valid = 1'b0;
        total++;
        if (out_valid2 !== 1'b1 || illegal2 !== 1'b1 || result2 !== 32'h0) begin
            bad++;
            $display("FAIL nomd_mul valid=%b il=%b result=%h exp=1/1/0", out_valid2, illegal2, result2);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL md_mul_busy valid=%b in_ready=%b exp=0/0", out_valid, in_ready);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_div();
        int seen;
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = 4'hD; a = 32'd100; b = 32'd7;
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || illegal !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset valid=%b result=%h z=%b il=%b rdy=%b exp=0/0/1/0/1",
                     out_valid, result, zero, illegal, in_ready);
        end
        cyc();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            cyc();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL reset_abort valid_cycles got=%0d exp=0", seen); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_op = 4'h0;
        a = 32'h0; b = 32'h0; out_ready = 1'b0;
        repeat (3) cyc();
        test_reset();
        rst = 1'b1;
        cyc();
        test_add_wrap();
        test_single_ops();
        test_muldiv();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_muldiv_disabled();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
